// File: rtl/tdc_pkg.sv
// Shared definitions for the start/stop TDC channel: state encoding and result payload.
package tdc_pkg;

    localparam int unsigned COARSE_W_DEF = 16;
    localparam int unsigned STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DEAD    = 3'd3,
        ST_REPORT  = 3'd4
    } tdc_state_e;

    // Result word as pushed into the readout FIFO.
    typedef struct packed {
        logic                    timeout;
        logic [COARSE_W_DEF-1:0] interval;
    } tdc_result_t;

endpackage

// File: rtl/tdc_coarse_counter.sv
// Coarse interval counter with synchronous clear, count enable and timeout compare.
module tdc_coarse_counter #(
    parameter int unsigned COARSE_W = 16,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                clear_i,
    input  logic                enable_i,
    output logic [COARSE_W-1:0] count_o,
    output logic                at_timeout_c
);

    logic [COARSE_W-1:0] count_q;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o      = count_q;
    assign at_timeout_c = (count_q == COARSE_W'(TIMEOUT));

endmodule

// File: rtl/tdc_hit_sequencer.sv
// Start/stop TDC channel controller: arm, measure, dead-time and report with
// fine-capture strobes, valid/ready result handshake and a missed-start counter.
module tdc_hit_sequencer
    import tdc_pkg::*;
#(
    parameter int unsigned COARSE_W    = COARSE_W_DEF,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned MISS_W      = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iArm,
    input  logic                iContinuous,
    input  logic                iStartRise,
    input  logic                iStopRise,
    input  logic                iReady,
    output logic                oStartLatch,
    output logic                oStopLatch,
    output logic [COARSE_W-1:0] oInterval,
    output logic                oTimeout,
    output logic                oValid,
    output logic                oBusy,
    output logic [MISS_W-1:0]   oMissed,
    output logic [STATE_W-1:0]  oState
);

    localparam int unsigned DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    tdc_state_e          state_q, state_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [COARSE_W-1:0] interval_q, interval_d;
    logic                timeout_q, timeout_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                start_latch_q, start_latch_d;
    logic                stop_latch_q, stop_latch_d;
    logic [MISS_W-1:0]   missed_q, missed_d;

    logic                cnt_clear;
    logic                cnt_en;
    logic [COARSE_W-1:0] cnt_value;
    logic                cnt_at_timeout;

    tdc_coarse_counter #(
        .COARSE_W (COARSE_W),
        .TIMEOUT  (TIMEOUT)
    ) u_coarse (
        .iClk         (iClk),
        .iRst         (iRst),
        .clear_i      (cnt_clear),
        .enable_i     (cnt_en),
        .count_o      (cnt_value),
        .at_timeout_c (cnt_at_timeout)
    );

    // Next-state, result capture and strobe generation.
    always_comb begin
        state_d       = state_q;
        dead_d        = dead_q;
        interval_d    = interval_q;
        timeout_d     = timeout_q;
        start_latch_d = 1'b0;
        stop_latch_d  = 1'b0;
        missed_d      = missed_q;
        cnt_clear     = 1'b1;
        cnt_en        = 1'b0;

        // Any start arriving while a measurement is in flight or unread is lost.
        if (iStartRise && (state_q inside {ST_MEASURE, ST_DEAD, ST_REPORT})
            && (missed_q != MISS_MAX)) begin
            missed_d = missed_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (iArm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (iStartRise) begin
                    state_d       = ST_MEASURE;
                    start_latch_d = 1'b1;
                    cnt_clear     = 1'b0;
                    cnt_en        = 1'b1;
                end
            end
            ST_MEASURE: begin
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                // A stop on the terminal-count cycle still counts as a real stop.
                if (iStopRise || cnt_at_timeout) begin
                    interval_d   = iStopRise ? cnt_value : COARSE_W'(TIMEOUT);
                    timeout_d    = !iStopRise;
                    stop_latch_d = iStopRise;
                    dead_d       = '0;
                    state_d      = (DEAD_CYCLES == 0) ? ST_REPORT : ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (dead_q == DEAD_W'(DEAD_LAST)) begin
                    state_d = ST_REPORT;
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end
            ST_REPORT: begin
                if (iReady) begin
                    state_d = iContinuous ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_REPORT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q       <= ST_IDLE;
            dead_q        <= '0;
            interval_q    <= '0;
            timeout_q     <= 1'b0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            start_latch_q <= 1'b0;
            stop_latch_q  <= 1'b0;
            missed_q      <= '0;
        end else begin
            state_q       <= state_d;
            dead_q        <= dead_d;
            interval_q    <= interval_d;
            timeout_q     <= timeout_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            start_latch_q <= start_latch_d;
            stop_latch_q  <= stop_latch_d;
            missed_q      <= missed_d;
        end
    end

    assign oStartLatch = start_latch_q;
    assign oStopLatch  = stop_latch_q;
    assign oInterval   = interval_q;
    assign oTimeout    = timeout_q;
    assign oValid      = valid_q;
    assign oBusy       = busy_q;
    assign oMissed     = missed_q;
    assign oState      = state_q;

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Directed bench for tdc_hit_sequencer (TIMEOUT=40, DEAD_CYCLES=4, MISS_W=8).
module tb_tdc_hit_sequencer;

    localparam int unsigned CW = 16;
    localparam int unsigned TO = 40;
    localparam int unsigned DC = 4;
    localparam int unsigned MW = 8;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iArm = 1'b0;
    logic          iContinuous = 1'b0;
    logic          iStartRise = 1'b0;
    logic          iStopRise = 1'b0;
    logic          iReady = 1'b0;
    logic          oStartLatch;
    logic          oStopLatch;
    logic [CW-1:0] oInterval;
    logic          oTimeout;
    logic          oValid;
    logic          oBusy;
    logic [MW-1:0] oMissed;
    logic [2:0]    oState;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    tdc_hit_sequencer #(
        .COARSE_W    (CW),
        .TIMEOUT     (TO),
        .DEAD_CYCLES (DC),
        .MISS_W      (MW)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iArm        (iArm),
        .iContinuous (iContinuous),
        .iStartRise  (iStartRise),
        .iStopRise   (iStopRise),
        .iReady      (iReady),
        .oStartLatch (oStartLatch),
        .oStopLatch  (oStopLatch),
        .oInterval   (oInterval),
        .oTimeout    (oTimeout),
        .oValid      (oValid),
        .oBusy       (oBusy),
        .oMissed     (oMissed),
        .oState      (oState)
    );

    always #5 iClk = ~iClk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int seen;

    initial begin
        // Reset state
        #2 iRst = 1'b1;
        tick(2);
        chk("rst_state", 32'(oState), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_interval", 32'(oInterval), 0);
        chk("rst_missed", 32'(oMissed), 0);
        chk("rst_strobes", 32'({oStartLatch, oStopLatch, oTimeout}), 0);
        #2 iRst = 1'b0;
        tick(1);

        // Stray pulses in IDLE are ignored
        iStartRise = 1'b1; iStopRise = 1'b1;
        tick(1);
        iStartRise = 1'b0; iStopRise = 1'b0;
        chk("idle_ignore_state", 32'(oState), 0);
        chk("idle_ignore_missed", 32'(oMissed), 0);

        // Basic: start at t0, stop at t0+37
        iArm = 1'b1; tick(1); iArm = 1'b0;
        chk("arm_state", 32'(oState), 1);
        chk("arm_busy", 32'(oBusy), 1);
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        chk("basic_startlatch", 32'(oStartLatch), 1);
        chk("basic_measure", 32'(oState), 2);
        tick(1);
        chk("basic_startlatch_off", 32'(oStartLatch), 0);
        tick(35);
        iStopRise = 1'b1; tick(1); iStopRise = 1'b0;
        chk("basic_stoplatch", 32'(oStopLatch), 1);
        chk("basic_interval", 32'(oInterval), 37);
        chk("basic_timeout", 32'(oTimeout), 0);
        chk("basic_dead", 32'(oState), 3);
        tick(1);
        chk("basic_stoplatch_off", 32'(oStopLatch), 0);
        tick(2);
        chk("basic_novalid_dead", 32'(oValid), 0);
        tick(1);
        chk("basic_valid", 32'(oValid), 1);
        chk("basic_report", 32'(oState), 4);
        tick(3);
        chk("basic_valid_hold", 32'({oValid, oInterval}), 32'({1'b1, 16'd37}));
        iReady = 1'b1; tick(1); iReady = 1'b0;
        chk("basic_valid_drop", 32'(oValid), 0);
        chk("basic_idle", 32'(oState), 0);
        chk("basic_idle_busy", 32'(oBusy), 0);

        // Timeout: start only
        iArm = 1'b1; tick(1); iArm = 1'b0;
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        tick(39);
        chk("to_still_measure", 32'(oState), 2);
        tick(1);
        chk("to_dead", 32'(oState), 3);
        chk("to_flag", 32'(oTimeout), 1);
        chk("to_interval", 32'(oInterval), TO);
        seen = int'(oStopLatch);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            seen += int'(oStopLatch);
        end
        chk("to_no_stoplatch", 32'(seen), 0);
        chk("to_valid", 32'(oValid), 1);
        iReady = 1'b1; tick(1); iReady = 1'b0;
        chk("to_back_idle", 32'(oState), 0);

        // Coincident start+stop in ARMED: stop ignored, later stop at +5
        iArm = 1'b1; tick(1); iArm = 1'b0;
        iStartRise = 1'b1; iStopRise = 1'b1; tick(1);
        iStartRise = 1'b0; iStopRise = 1'b0;
        chk("coinc_measure", 32'(oState), 2);
        chk("coinc_no_stoplatch", 32'(oStopLatch), 0);
        tick(4);
        iStopRise = 1'b1; tick(1); iStopRise = 1'b0;
        chk("coinc_interval", 32'(oInterval), 5);
        chk("coinc_stoplatch", 32'(oStopLatch), 1);
        tick(4);
        iReady = 1'b1; tick(1); iReady = 1'b0;
        chk("coinc_idle", 32'(oState), 0);

        // Stop on the terminal-count cycle wins
        iArm = 1'b1; tick(1); iArm = 1'b0;
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        tick(39);
        iStopRise = 1'b1; tick(1); iStopRise = 1'b0;
        chk("tcstop_timeout", 32'(oTimeout), 0);
        chk("tcstop_interval", 32'(oInterval), TO);
        chk("tcstop_stoplatch", 32'(oStopLatch), 1);
        tick(4);
        iReady = 1'b1; tick(1); iReady = 1'b0;

        // Missed starts in MEASURE, DEAD, REPORT, then saturation
        chk("miss_zero", 32'(oMissed), 0);
        iArm = 1'b1; tick(1); iArm = 1'b0;
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        chk("miss_measure", 32'(oMissed), 1);
        iStopRise = 1'b1; tick(1); iStopRise = 1'b0;
        chk("miss_interval", 32'(oInterval), 2);
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        chk("miss_dead", 32'(oMissed), 2);
        tick(3);
        chk("miss_report", 32'(oState), 4);
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        chk("miss_three", 32'(oMissed), 3);
        for (int i = 0; i < 300; i++) begin
            iStartRise = 1'b1; tick(1); iStartRise = 1'b0; tick(1);
        end
        chk("miss_saturate", 32'(oMissed), 255);
        chk("miss_valid_hold", 32'({oValid, oInterval}), 32'({1'b1, 16'd2}));
        iReady = 1'b1; tick(1); iReady = 1'b0;

        // Backpressure, then continuous re-arm
        iContinuous = 1'b1;
        iArm = 1'b1; tick(1); iArm = 1'b0;
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        tick(2);
        iStopRise = 1'b1; tick(1); iStopRise = 1'b0;
        tick(4);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(oValid === 1'b1 && oInterval === 16'd3 && oTimeout === 1'b0)) seen++;
            tick(1);
        end
        chk("bp_stable", 32'(seen), 0);
        iReady = 1'b1; tick(1); iReady = 1'b0;
        chk("bp_rearm_state", 32'(oState), 1);
        chk("bp_rearm_valid", 32'(oValid), 0);
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        tick(6);
        iStopRise = 1'b1; tick(1); iStopRise = 1'b0;
        chk("bp_second_interval", 32'(oInterval), 7);
        tick(4);
        chk("bp_second_valid", 32'(oValid), 1);
        iContinuous = 1'b0;
        iReady = 1'b1; tick(1); iReady = 1'b0;
        chk("bp_idle", 32'(oState), 0);

        // Asynchronous reset mid-MEASURE
        iArm = 1'b1; tick(1); iArm = 1'b0;
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        tick(5);
        #2 iRst = 1'b1;
        #1;
        chk("arst_state", 32'(oState), 0);
        chk("arst_outputs", 32'({oBusy, oValid, oStartLatch, oStopLatch, oTimeout}), 0);
        chk("arst_interval_missed", 32'({oInterval, oMissed}), 0);
        #3 iRst = 1'b0;
        iStopRise = 1'b1; iStartRise = 1'b1; tick(1);
        iStopRise = 1'b0; iStartRise = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            seen += int'(oStopLatch) + int'(oValid) + int'(oBusy);
            tick(1);
        end
        chk("arst_quiet", 32'(seen), 0);
        chk("arst_missed", 32'(oMissed), 0);
        iArm = 1'b1; tick(1); iArm = 1'b0;
        iStartRise = 1'b1; tick(1); iStartRise = 1'b0;
        tick(1);
        iStopRise = 1'b1; tick(1); iStopRise = 1'b0;
        chk("arst_recover_interval", 32'(oInterval), 2);
        chk("arst_recover_stoplatch", 32'(oStopLatch), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
